// File: rtl/rfx_prescaler_mc.sv
// Multi-channel AXI4-Lite programmable clock-enable prescaler (pulse or toggle output per channel).
// Latency: register write takes effect on the handshake edge; read data is registered one cycle after arready.
// Backpressure: bvalid/rvalid hold until bready/rready; new address phases are refused while a response is pending.
module rfx_prescaler_mc #(
    parameter int NUM_CH               = 4,
    parameter int CNT_WIDTH            = 32,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 6
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    input  logic                              sync_i,
    output logic [NUM_CH-1:0]                 tick_o,
    output logic [NUM_CH-1:0]                 wave_o
);

    localparam int AW = C_S00_AXI_ADDR_WIDTH;
    localparam int IW = AW - 2;
    localparam int DW = C_S00_AXI_DATA_WIDTH;

    // Programmable state
    logic [NUM_CH-1:0]    en;
    logic [NUM_CH-1:0]    mode;
    logic [NUM_CH-1:0]    status;
    logic [CNT_WIDTH-1:0] div    [NUM_CH];
    logic                 sw_resync;

    // Channel state
    logic [CNT_WIDTH-1:0] cnt    [NUM_CH];
    logic [CNT_WIDTH-1:0] shadow [NUM_CH];
    logic [NUM_CH-1:0]    tick_q;
    logic [NUM_CH-1:0]    wave_q;
    logic [NUM_CH-1:0]    ev;
    logic                 resync;

    // Bus-side decode
    logic                 wr_en;
    logic                 rd_en;
    logic [IW-1:0]        widx;
    logic [IW-1:0]        ridx;
    logic [DW-1:0]        wmask;
    logic                 wr_ctrl;
    logic                 wr_stat;
    logic [NUM_CH-1:0]    wr_div;
    logic [NUM_CH-1:0]    en_wr;
    logic [NUM_CH-1:0]    mode_wr;
    logic [NUM_CH-1:0]    st_clr;
    logic [CNT_WIDTH-1:0] div_wr [NUM_CH];
    logic [DW-1:0]        rd_val;

    // Protection bits and byte-lane address bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;
    assign wr_en  = s00_axi_awready & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_en  = s00_axi_arready & s00_axi_arvalid;
    assign widx   = s00_axi_awaddr[AW-1:2];
    assign ridx   = s00_axi_araddr[AW-1:2];
    assign resync = sync_i | sw_resync;
    assign tick_o = tick_q & ~mode & en;
    assign wave_o = wave_q & mode & en;

    // Write decode, byte-strobe merge and terminal-count detection
    always_comb begin
        wmask   = '0;
        wr_ctrl = 1'b0;
        wr_stat = 1'b0;
        wr_div  = '0;
        for (int b = 0; b < DW / 8; b++) begin
            wmask[8*b +: 8] = {8{s00_axi_wstrb[b]}};
        end
        if (wr_en && widx == IW'(0)) wr_ctrl = 1'b1;
        if (wr_en && widx == IW'(1)) wr_stat = 1'b1;
        for (int n = 0; n < NUM_CH; n++) begin
            if (wr_en && widx == IW'(n + 2)) wr_div[n] = 1'b1;
            div_wr[n] = (div[n] & ~wmask[CNT_WIDTH-1:0]) | (s00_axi_wdata[CNT_WIDTH-1:0] & wmask[CNT_WIDTH-1:0]);
            // A resync in the same cycle swallows the event
            ev[n] = en[n] & (cnt[n] == shadow[n]) & ~resync;
        end
        en_wr   = (en & ~wmask[NUM_CH-1:0]) | (s00_axi_wdata[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
        mode_wr = (mode & ~wmask[8 +: NUM_CH]) | (s00_axi_wdata[8 +: NUM_CH] & wmask[8 +: NUM_CH]);
        st_clr  = wr_stat ? (s00_axi_wdata[NUM_CH-1:0] & wmask[NUM_CH-1:0]) : '0;
    end

    // Read mux; unmapped words and unimplemented bits return zero
    always_comb begin
        rd_val = '0;
        if (ridx == IW'(0)) begin
            rd_val[NUM_CH-1:0]  = en;
            rd_val[8 +: NUM_CH] = mode;
        end else if (ridx == IW'(1)) begin
            rd_val[NUM_CH-1:0] = status;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (ridx == IW'(n + 2)) rd_val[CNT_WIDTH-1:0] = div[n];
            end
        end
    end

    // AXI handshakes and register file
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            en              <= '0;
            mode            <= '0;
            status          <= '0;
            sw_resync       <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) div[n] <= '0;
        end else begin
            s00_axi_awready <= s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid & ~s00_axi_awready;
            s00_axi_wready  <= s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid & ~s00_axi_awready;
            if (wr_en) s00_axi_bvalid <= 1'b1;
            else if (s00_axi_bready) s00_axi_bvalid <= 1'b0;

            s00_axi_arready <= s00_axi_arvalid & ~s00_axi_rvalid & ~s00_axi_arready;
            if (rd_en) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_val;
            end else if (s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end

            if (wr_ctrl) begin
                en   <= en_wr;
                mode <= mode_wr;
            end
            sw_resync <= wr_ctrl & s00_axi_wdata[31] & s00_axi_wstrb[3];
            status    <= (status & ~st_clr) | ev;
            for (int n = 0; n < NUM_CH; n++) begin
                if (wr_div[n]) div[n] <= div_wr[n];
            end
        end
    end

    // Per-channel counters: reload the shadow divider only at terminal count, resync or while idle
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            tick_q <= '0;
            wave_q <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                cnt[n]    <= '0;
                shadow[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (!en[n] || resync) begin
                    cnt[n]    <= '0;
                    shadow[n] <= div[n];
                    tick_q[n] <= 1'b0;
                    wave_q[n] <= 1'b0;
                end else if (ev[n]) begin
                    cnt[n]    <= '0;
                    shadow[n] <= div[n];
                    tick_q[n] <= ~mode[n];
                    wave_q[n] <= mode[n] & ~wave_q[n];
                end else begin
                    cnt[n]    <= cnt[n] + 1'b1;
                    tick_q[n] <= 1'b0;
                    if (!mode[n]) wave_q[n] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rfx_prescaler_mc.sv
module tb_rfx_prescaler_mc;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic        sync_i;
    logic [NCH-1:0] tick_o, wave_o;

    always #5 clk = ~clk;

    rfx_prescaler_mc #(.NUM_CH(NCH), .CNT_WIDTH(32), .C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(6)) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rstn),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .sync_i(sync_i), .tick_o(tick_o), .wave_o(wave_o)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int unsigned wr_edge;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } rexp_t;
    rexp_t sb[$];

    typedef struct {
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [5:0]  raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s timed out", name);
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = awready & wready;
        end
        if (!ok) timeout("wr_handshake");
        @(negedge clk);
        wr_edge = cyc;
        awvalid = 0; wvalid = 0;
        check("wr_resp", {29'b0, bvalid, bresp}, 32'h4);
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] exp, input string name);
        bit ok = 0;
        rexp_t r;
        @(negedge clk);
        araddr = a; arvalid = 1; rready = 1;
        sb.push_back('{exp, name});
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = arready;
        end
        if (!ok) timeout("rd_handshake");
        @(negedge clk);
        arvalid = 0;
        r = sb.pop_front();
        if (rvalid) begin
            check(r.name, rdata, r.exp);
            check("rresp", {30'b0, rresp}, 32'h0);
        end else begin
            timeout(r.name);
        end
    endtask

    initial begin
        logic [5:0] rst_addrs [7];
        int unsigned en_cyc, rs_cyc;
        bit ok;

        rstn = 0; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arprot = 0; arvalid = 0; rready = 0; sync_i = 0;
        repeat (4) @(negedge clk);
        rstn = 1;
        @(negedge clk);
        check("rst_ready", {28'b0, awready, wready, arready, 1'b0}, 32'h0);
        check("rst_valid", {30'b0, bvalid, rvalid}, 32'h0);
        check("rst_outs", {24'b0, tick_o, wave_o}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        rst_addrs = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h3C};
        foreach (rst_addrs[i]) axi_read(rst_addrs[i], 32'h0, $sformatf("rst_reg_%0h", rst_addrs[i]));

        // Register write/read vectors
        vt[0] = '{6'h08, 32'h12345678, 4'hF, 6'h08, 32'h12345678};
        vt[1] = '{6'h14, 32'hFFFF0000, 4'h3, 6'h14, 32'h00000000};
        vt[2] = '{6'h14, 32'hFFFFFFFF, 4'h4, 6'h14, 32'h00FF0000};
        vt[3] = '{6'h0C, 32'h000000A5, 4'h1, 6'h0C, 32'h000000A5};
        vt[4] = '{6'h00, 32'hFFFFFFFF, 4'h2, 6'h00, 32'h00000F00};
        vt[5] = '{6'h00, 32'h00000000, 4'h2, 6'h00, 32'h00000000};
        vt[6] = '{6'h3C, 32'hFFFFFFFF, 4'hF, 6'h3C, 32'h00000000};
        vt[7] = '{6'h18, 32'hFFFFFFFF, 4'hF, 6'h18, 32'h00000000};
        vt[8] = '{6'h04, 32'h0000000F, 4'hF, 6'h04, 32'h00000000};
        vt[9] = '{6'h10, 32'h5A5A5A5A, 4'hA, 6'h10, 32'h5A005A00};
        for (int i = 0; i < 10; i++) begin
            axi_write(vt[i].waddr, vt[i].wdata, vt[i].wstrb);
            axi_read(vt[i].raddr, vt[i].exp, $sformatf("vec%0d", i));
        end

        // Pulse mode, DIV=3: period 4, first tick 4 cycles after the enabling edge
        axi_write(6'h08, 32'd3, 4'hF);
        axi_write(6'h00, 32'h1, 4'hF);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("p4_tick0_k%0d", k), 32'(tick_o[0]), 32'(k % 4 == 0));
            check($sformatf("p4_wave0_k%0d", k), 32'(wave_o[0]), 32'h0);
        end
        axi_write(6'h00, 32'h0, 4'hF);
        axi_read(6'h04, 32'h1, "status_set");
        axi_write(6'h04, 32'h1, 4'hF);
        axi_read(6'h04, 32'h0, "status_w1c");

        // Toggle mode, DIV=0: clk/2 on wave_o[1]
        axi_write(6'h0C, 32'd0, 4'hF);
        axi_write(6'h00, 32'h202, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("tg_wave1_k%0d", k), 32'(wave_o[1]), 32'(k % 2));
            check($sformatf("tg_tick1_k%0d", k), 32'(tick_o[1]), 32'h0);
        end
        axi_write(6'h00, 32'h0, 4'hF);

        // DIV change mid-period: current 10-cycle period completes, then period 2
        axi_write(6'h08, 32'd9, 4'hF);
        axi_write(6'h00, 32'h1, 4'hF);
        en_cyc = wr_edge;
        while (cyc < en_cyc + 3) @(negedge clk);
        axi_write(6'h08, 32'd1, 4'hF);
        while (cyc - en_cyc < 16) begin
            int k;
            @(negedge clk);
            k = int'(cyc - en_cyc);
            check($sformatf("dchg_tick0_k%0d", k), 32'(tick_o[0]), 32'(k == 10 || (k > 10 && k % 2 == 0)));
        end
        axi_write(6'h00, 32'h0, 4'hF);
        axi_write(6'h04, 32'hF, 4'hF);

        // External resync realigns ch0 (DIV=7) and ch2 (DIV=4)
        axi_write(6'h08, 32'd7, 4'hF);
        axi_write(6'h10, 32'd4, 4'hF);
        axi_write(6'h00, 32'h5, 4'hF);
        repeat (3) @(negedge clk);
        sync_i = 1;
        @(negedge clk);
        sync_i = 0;
        rs_cyc = cyc;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check($sformatf("rs_tick0_k%0d", k), 32'(tick_o[0]), 32'(k % 8 == 0));
            check($sformatf("rs_tick2_k%0d", k), 32'(tick_o[2]), 32'(k % 5 == 0));
        end

        // Software resync: takes effect one edge after the CTRL write edge
        axi_write(6'h00, 32'h80000005, 4'hF);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            check($sformatf("sw_tick0_k%0d", k), 32'(tick_o[0]), 32'(k > 1 && (k - 1) % 8 == 0));
            check($sformatf("sw_tick2_k%0d", k), 32'(tick_o[2]), 32'(k > 1 && (k - 1) % 5 == 0));
        end
        axi_read(6'h00, 32'h5, "ctrl_resync_reads0");
        axi_write(6'h00, 32'h0, 4'hF);
        axi_read(6'h04, 32'h5, "status_ch0_ch2");

        // DIV=0 pulse mode holds tick high; mode switch drops the tick output at once
        axi_write(6'h14, 32'd0, 4'hF);
        axi_write(6'h00, 32'h8, 4'hF);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("d0_tick3_k%0d", k), 32'(tick_o[3]), 32'h1);
        end
        axi_write(6'h00, 32'h808, 4'hF);
        check("mode_sw_tick3", 32'(tick_o[3]), 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("mode_sw_wave3_k%0d", k), 32'(wave_o[3]), 32'(k % 2));
        end
        axi_write(6'h00, 32'h0, 4'hF);
        check("disable_outs", {24'b0, tick_o, wave_o}, 32'h0);

        // bready held low: response held, no second write accepted
        @(negedge clk);
        awaddr = 6'h10; wdata = 32'h11; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = awready;
        end
        if (!ok) timeout("hold_handshake");
        @(negedge clk);
        wdata = 32'h22;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold_bvalid_%0d", k), 32'(bvalid), 32'h1);
            check($sformatf("hold_awready_%0d", k), 32'(awready), 32'h0);
            @(negedge clk);
        end
        awvalid = 0; wvalid = 0; bready = 1;
        @(negedge clk);
        check("hold_bvalid_drop", 32'(bvalid), 32'h0);
        axi_read(6'h10, 32'h11, "hold_single_write");

        // rready held low keeps rdata; reset aborts the pending response
        @(negedge clk);
        araddr = 6'h10; arvalid = 1; rready = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = arready;
        end
        if (!ok) timeout("rhold_handshake");
        @(negedge clk);
        arvalid = 0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rhold_data_%0d", k), rdata, 32'h11);
            check($sformatf("rhold_valid_%0d", k), 32'(rvalid), 32'h1);
            @(negedge clk);
        end
        rstn = 0;
        @(negedge clk);
        check("abort_rvalid", 32'(rvalid), 32'h0);
        check("abort_rdata", rdata, 32'h0);
        rstn = 1; rready = 1;
        axi_read(6'h10, 32'h0, "abort_div2_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rfx_prescaler_mc.md
Name: rfx_prescaler_mc

Overview:
Multi-channel, AXI4-Lite-programmable clock-enable prescaler; next generation of the single-channel rfx_prescaler peripheral. Each of NUM_CH independent channels divides the bus clock by a programmable integer. Each channel produces either a one-cycle tick or a 50% toggle wave. Sits in rfx_axibase behind the PS AXI GP interconnect and feeds clock-enables to acquisition and timing logic.

Parameters:
NUM_CH, 4, number of prescaler channels (1..8)
CNT_WIDTH, 32, divider/counter width (1..32)
C_S00_AXI_DATA_WIDTH, 32, AXI-Lite data width (fixed 32)
C_S00_AXI_ADDR_WIDTH, 6, byte address width; must cover (2+NUM_CH) words

Ports:
s00_axi_aclk  in  1  bus and core clock
s00_axi_aresetn  in  1  synchronous active-low reset
s00_axi_awaddr/awprot/awvalid/awready  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel
s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel
s00_axi_araddr/arprot/arvalid/arready  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel
s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel
sync_i  in  1  external resync strobe, active high, sampled each cycle
tick_o  out  NUM_CH  per-channel one-cycle tick (pulse mode)
wave_o  out  NUM_CH  per-channel toggle output (toggle mode)

Behaviour:
- Single clock domain. Reset is synchronous and active-low. Reset clears all registers, counters, shadows, tick_o, wave_o, all *ready/*valid, bresp, rresp and rdata to 0.
- Register map (word offsets):
  - 0x00 CTRL: [NUM_CH-1:0] enable; [8+NUM_CH-1:8] mode (0=pulse, 1=toggle); [31] resync, write-only, self-clearing, reads 0.
  - 0x04 STATUS: [NUM_CH-1:0] sticky tick flags, write-1-to-clear.
  - 0x08+4n DIV_n: [CNT_WIDTH-1:0] divider; upper bits read 0.
  - Unmapped address: writes ignored, reads return 0.
  - WSTRB honoured per byte on all writable registers.
- AXI write:
  - awready and wready pulse together for one cycle when awvalid & wvalid & !bvalid.
  - The register updates on that edge. bvalid asserts the next cycle and holds until bready.
  - bresp is always OKAY (00).
- AXI read:
  - arready pulses one cycle when arvalid & !rvalid.
  - rvalid and rdata are registered the next cycle. rdata holds stable until rready.
  - rresp is always OKAY.
  - Simultaneous read and write are independent.
- Channel counter:
  - Period is DIV+1 cycles.
  - When enabled, cnt increments each cycle. When cnt==div_shadow: tick event, cnt<=0, div_shadow<=DIV_n.
  - First tick occurs DIV+1 cycles after the enabling write edge.
  - Pulse mode: tick_o[n]=1 for exactly the event cycle; wave_o[n]=0.
  - Toggle mode: wave_o[n] toggles on each event; tick_o[n]=0.
  - DIV=0: event every cycle. Pulse mode gives tick_o constantly high; toggle mode gives clk/2.
  - A DIV write while running takes effect only at the next terminal count. No glitch or truncated period.
  - While disabled: cnt=0, div_shadow tracks DIV_n continuously, tick_o=0, wave_o=0.
- Mode change while enabled: outputs of the new mode start at the next event; the old-mode output is forced 0 immediately.
- Resync: CTRL[31] write or sync_i=1. On the following edge, all enabled counters go to 0, wave_o goes to 0, and shadows reload. Sticky flags are unaffected. Resync in the same cycle as a terminal count wins: no tick is generated.
- STATUS: flag n sets on each event of channel n in either mode. If a W1C and a set land in the same cycle, set wins.
- Reset asserted mid-transaction aborts it: valid signals drop and no response is issued.

Test Plan:
- Reset, then read all registers -> all 0x00000000, rresp=00; unmapped 0x3C reads 0 with OKAY.
- DIV_0=3, CTRL=0x1 -> tick_o[0] pulses every 4 cycles; first pulse 4 cycles after the write edge; STATUS reads 0x1; writing 0x1 to STATUS clears it.
- DIV_1=0, CTRL=0x202 (ch1 toggle) -> wave_o[1] is a clk/2 square wave; tick_o[1] stays 0.
- Ch0 running with DIV=9, write DIV_0=1 mid-period -> current period completes at 10 cycles, then periods of 2 cycles.
- Ch0 DIV=7, ch2 DIV=4 enabled; pulse sync_i for 1 cycle -> both counters realign; next ticks occur 8 and 5 cycles after the resync edge.
- Write 0xFFFF0000 to DIV_3 with wstrb=0b0011 -> DIV_3 reads 0x00000000. Hold bready low 5 cycles -> bvalid held, no second write accepted.
